// File: rtl/axi4_stream_to_axi4.sv
// axi4_stream_to_axi4
//   Writes one AXI4-Stream packet into memory through the write channels of
//   an AXI4 master port. Each packet is split into INCR bursts of at most 256
//   beats that never cross a 4 KB boundary; AW, W and B run strictly one burst
//   at a time. The read channel is tied off.
//
// Ports
//   clk_i, rst_i          clock, asynchronous active-high reset
//   pkt_size_i, addr_i    packet length (bytes) and byte address, sampled on start
//   wr_stb_i              start request, honoured only when idle
//   busy_o, done_o, err_o status: busy, end-of-packet pulse, sticky error
//   pkt_*                 AXI4-Stream slave (packet source)
//   mem_aw*/w*/b*         AXI4 write channels (master)
//   mem_ar*/r*            AXI4 read channels, unused and tied off
//   Outputs suffixed _c are combinational; all others come from flops.
module axi4_stream_to_axi4 #(
  parameter int unsigned DATA_WIDTH         = 64,
  parameter int unsigned ADDR_WIDTH         = 32,
  parameter int unsigned ID_WIDTH           = 1,
  parameter int unsigned AWUSER_WIDTH       = 1,
  parameter int unsigned WUSER_WIDTH        = 1,
  parameter int unsigned ARUSER_WIDTH       = 1,
  parameter int unsigned TUSER_WIDTH        = 1,
  parameter int unsigned TDEST_WIDTH        = 1,
  parameter int unsigned MAX_PKT_SIZE_B     = 2048,
  parameter int unsigned MAX_PKT_SIZE_WIDTH = $clog2(MAX_PKT_SIZE_B*4)
) (
  input  logic                          clk_i,
  input  logic                          rst_i,
  input  logic [MAX_PKT_SIZE_WIDTH-1:0] pkt_size_i,
  input  logic [ADDR_WIDTH-1:0]         addr_i,
  input  logic                          wr_stb_i,
  output logic                          busy_o,
  output logic                          done_o,
  output logic                          err_o,
  // stream slave
  input  logic [DATA_WIDTH-1:0]         pkt_tdata_i,
  input  logic                          pkt_tvalid_i,
  output logic                          pkt_tready_c,
  input  logic                          pkt_tlast_i,
  input  logic [TUSER_WIDTH-1:0]        pkt_tuser_i,
  input  logic [TDEST_WIDTH-1:0]        pkt_tdest_i,
  // write address channel
  output logic [ID_WIDTH-1:0]           mem_awid_o,
  output logic [ADDR_WIDTH-1:0]         mem_awaddr_o,
  output logic [7:0]                    mem_awlen_o,
  output logic [2:0]                    mem_awsize_o,
  output logic [1:0]                    mem_awburst_o,
  output logic                          mem_awlock_o,
  output logic [3:0]                    mem_awcache_o,
  output logic [2:0]                    mem_awprot_o,
  output logic [3:0]                    mem_awqos_o,
  output logic [3:0]                    mem_awregion_o,
  output logic [AWUSER_WIDTH-1:0]       mem_awuser_o,
  output logic                          mem_awvalid_o,
  input  logic                          mem_awready_i,
  // write data channel
  output logic [DATA_WIDTH-1:0]         mem_wdata_c,
  output logic [DATA_WIDTH/8-1:0]       mem_wstrb_c,
  output logic                          mem_wlast_c,
  output logic [WUSER_WIDTH-1:0]        mem_wuser_o,
  output logic                          mem_wvalid_c,
  input  logic                          mem_wready_i,
  // write response channel
  input  logic [ID_WIDTH-1:0]           mem_bid_i,
  input  logic [1:0]                    mem_bresp_i,
  input  logic                          mem_bvalid_i,
  output logic                          mem_bready_c,
  // read address channel (tied off)
  output logic [ID_WIDTH-1:0]           mem_arid_o,
  output logic [ADDR_WIDTH-1:0]         mem_araddr_o,
  output logic [7:0]                    mem_arlen_o,
  output logic [2:0]                    mem_arsize_o,
  output logic [1:0]                    mem_arburst_o,
  output logic                          mem_arlock_o,
  output logic [3:0]                    mem_arcache_o,
  output logic [2:0]                    mem_arprot_o,
  output logic [3:0]                    mem_arqos_o,
  output logic [3:0]                    mem_arregion_o,
  output logic [ARUSER_WIDTH-1:0]       mem_aruser_o,
  output logic                          mem_arvalid_o,
  // read data channel (ignored)
  input  logic [ID_WIDTH-1:0]           mem_rid_i,
  input  logic [DATA_WIDTH-1:0]         mem_rdata_i,
  input  logic [1:0]                    mem_rresp_i,
  input  logic                          mem_rlast_i,
  input  logic                          mem_rvalid_i,
  output logic                          mem_rready_o
);

  localparam int unsigned BPW    = DATA_WIDTH / 8;
  localparam int unsigned OFS_W  = $clog2(BPW);
  localparam int unsigned PW     = MAX_PKT_SIZE_WIDTH;
  // wide enough for words_left, the 4 KB distance (up to 4096) and 256
  localparam int unsigned CALC_W = ((PW > 13) ? PW : 13) + 1;

  typedef enum logic [2:0] {
    IDLE_S       = 3'd0,
    CALC_BURST_S = 3'd1,
    ADDR_S       = 3'd2,
    DATA_S       = 3'd3,
    RESP_S       = 3'd4
  } state_e;

  state_e                  state_q, state_d;
  logic [ADDR_WIDTH-1:0]   cur_addr_q, cur_addr_d;
  logic [PW-1:0]           words_left_q, words_left_d;
  logic [8:0]              burst_left_q, burst_left_d;
  logic [BPW-1:0]          last_strb_q, last_strb_d;
  logic [ADDR_WIDTH-1:0]   awaddr_q, awaddr_d;
  logic [7:0]              awlen_q, awlen_d;
  logic                    awvalid_q, awvalid_d;
  logic                    busy_q, busy_d;
  logic                    done_q, done_d;
  logic                    err_q, err_d;

  logic [PW:0]             words_calc_c;
  logic [OFS_W-1:0]        rem_c;
  logic [BPW:0]            strb_hot_c;
  logic [BPW-1:0]          strb_calc_c;
  logic [CALC_W-1:0]       words_to_bnd_c;
  logic [CALC_W-1:0]       burst_len_c;
  logic                    w_hs_c;
  logic                    final_beat_c;

  // Start-time sizing: beat count and strobe for the trailing partial word.
  always_comb begin
    words_calc_c = ({1'b0, pkt_size_i} + (PW+1)'(BPW - 1)) >> OFS_W;
    rem_c        = pkt_size_i[OFS_W-1:0];
    strb_hot_c   = (BPW+1)'(1) << rem_c;
    strb_calc_c  = (rem_c == '0) ? '1 : BPW'(strb_hot_c - (BPW+1)'(1));
  end

  // Burst sizing: min(words_left, 256, words to the next 4 KB boundary).
  always_comb begin
    words_to_bnd_c = CALC_W'((13'h1000 - {1'b0, cur_addr_q[11:0]}) >> OFS_W);
    burst_len_c    = CALC_W'(words_left_q);
    if (words_to_bnd_c < burst_len_c) burst_len_c = words_to_bnd_c;
    if (CALC_W'(256) < burst_len_c)   burst_len_c = CALC_W'(256);
  end

  assign w_hs_c       = pkt_tvalid_i && mem_wready_i;
  assign final_beat_c = (words_left_q == PW'(1));

  // Next-state and register updates.
  always_comb begin
    state_d      = state_q;
    cur_addr_d   = cur_addr_q;
    words_left_d = words_left_q;
    burst_left_d = burst_left_q;
    last_strb_d  = last_strb_q;
    awaddr_d     = awaddr_q;
    awlen_d      = awlen_q;
    awvalid_d    = awvalid_q;
    err_d        = err_q;
    done_d       = 1'b0;

    unique case (state_q)
      IDLE_S: begin
        if (wr_stb_i) begin
          err_d = 1'b0;
          if (pkt_size_i == '0) begin
            // empty packet: report completion without touching the bus
            done_d = 1'b1;
          end else begin
            cur_addr_d   = {addr_i[ADDR_WIDTH-1:OFS_W], OFS_W'(0)};
            words_left_d = PW'(words_calc_c);
            last_strb_d  = strb_calc_c;
            state_d      = CALC_BURST_S;
          end
        end
      end
      CALC_BURST_S: begin
        awaddr_d     = cur_addr_q;
        awlen_d      = 8'(burst_len_c - CALC_W'(1));
        burst_left_d = 9'(burst_len_c);
        awvalid_d    = 1'b1;
        state_d      = ADDR_S;
      end
      ADDR_S: begin
        if (mem_awready_i) begin
          awvalid_d = 1'b0;
          state_d   = DATA_S;
        end
      end
      DATA_S: begin
        if (w_hs_c) begin
          words_left_d = words_left_q - PW'(1);
          burst_left_d = burst_left_q - 9'd1;
          cur_addr_d   = cur_addr_q + ADDR_WIDTH'(BPW);
          // stream framing must agree with the latched length
          if (pkt_tlast_i != final_beat_c) err_d = 1'b1;
          if (burst_left_q == 9'd1) state_d = RESP_S;
        end
      end
      RESP_S: begin
        if (mem_bvalid_i) begin
          if (mem_bresp_i != 2'b00) err_d = 1'b1;
          if (words_left_q != '0) begin
            state_d = CALC_BURST_S;
          end else begin
            state_d = IDLE_S;
            done_d  = 1'b1;
          end
        end
      end
      default: state_d = IDLE_S;
    endcase

    busy_d = (state_d != IDLE_S);
  end

  // State and datapath registers.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q      <= IDLE_S;
      cur_addr_q   <= '0;
      words_left_q <= '0;
      burst_left_q <= '0;
      last_strb_q  <= '0;
      awaddr_q     <= '0;
      awlen_q      <= '0;
      awvalid_q    <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      cur_addr_q   <= cur_addr_d;
      words_left_q <= words_left_d;
      burst_left_q <= burst_left_d;
      last_strb_q  <= last_strb_d;
      awaddr_q     <= awaddr_d;
      awlen_q      <= awlen_d;
      awvalid_q    <= awvalid_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      err_q        <= err_d;
    end
  end

  // Stream-to-W passthrough; only live while a burst's data phase is open.
  assign pkt_tready_c = (state_q == DATA_S) && mem_wready_i;
  assign mem_wvalid_c = (state_q == DATA_S) && pkt_tvalid_i;
  assign mem_wdata_c  = pkt_tdata_i;
  assign mem_wstrb_c  = final_beat_c ? last_strb_q : '1;
  assign mem_wlast_c  = (state_q == DATA_S) && (burst_left_q == 9'd1);
  assign mem_wuser_o  = '0;
  assign mem_bready_c = (state_q == RESP_S);

  assign busy_o         = busy_q;
  assign done_o         = done_q;
  assign err_o          = err_q;

  assign mem_awid_o     = '0;
  assign mem_awaddr_o   = awaddr_q;
  assign mem_awlen_o    = awlen_q;
  assign mem_awsize_o   = 3'(OFS_W);
  assign mem_awburst_o  = 2'b01;
  assign mem_awlock_o   = 1'b0;
  assign mem_awcache_o  = '0;
  assign mem_awprot_o   = '0;
  assign mem_awqos_o    = '0;
  assign mem_awregion_o = '0;
  assign mem_awuser_o   = '0;
  assign mem_awvalid_o  = awvalid_q;

  assign mem_arid_o     = '0;
  assign mem_araddr_o   = '0;
  assign mem_arlen_o    = '0;
  assign mem_arsize_o   = '0;
  assign mem_arburst_o  = '0;
  assign mem_arlock_o   = 1'b0;
  assign mem_arcache_o  = '0;
  assign mem_arprot_o   = '0;
  assign mem_arqos_o    = '0;
  assign mem_arregion_o = '0;
  assign mem_aruser_o   = '0;
  assign mem_arvalid_o  = 1'b0;
  assign mem_rready_o   = 1'b1;

  // Inputs with no function in a write-only mover.
  logic unused_inputs;
  assign unused_inputs = ^{addr_i[OFS_W-1:0], pkt_tuser_i, pkt_tdest_i, mem_bid_i,
                           mem_rid_i, mem_rdata_i, mem_rresp_i, mem_rlast_i, mem_rvalid_i};

endmodule

// File: tb/tb_axi4_stream_to_axi4.sv
// Bench for axi4_stream_to_axi4: a table of packet transfers is pushed through
// a stream source and an AXI write slave; expected AW/W traffic comes from a
// small burst-splitting model and is popped as the DUT issues handshakes.
module tb_axi4_stream_to_axi4;

  localparam int unsigned DW = 64;
  localparam int unsigned AW = 32;
  localparam int unsigned PW = 13;

  logic clk, rst;
  logic [PW-1:0] pkt_size;
  logic [AW-1:0] addr;
  logic wr_stb, busy, done, err;
  logic [DW-1:0] tdata;
  logic tvalid, tready, tlast;
  logic [0:0] awid, awuser, wuser, arid, aruser;
  logic [AW-1:0] awaddr, araddr;
  logic [7:0] awlen, arlen, wstrb;
  logic [2:0] awsize, awprot, arsize, arprot;
  logic [1:0] awburst, arburst, bresp;
  logic awlock, arlock, awvalid, awready, wlast, wvalid, wready, bvalid, bready, arvalid, rready;
  logic [3:0] awcache, awqos, awregion, arcache, arqos, arregion;
  logic [DW-1:0] wdata;

  axi4_stream_to_axi4 dut (
    .clk_i(clk), .rst_i(rst), .pkt_size_i(pkt_size), .addr_i(addr), .wr_stb_i(wr_stb),
    .busy_o(busy), .done_o(done), .err_o(err),
    .pkt_tdata_i(tdata), .pkt_tvalid_i(tvalid), .pkt_tready_c(tready), .pkt_tlast_i(tlast),
    .pkt_tuser_i(1'b0), .pkt_tdest_i(1'b0),
    .mem_awid_o(awid), .mem_awaddr_o(awaddr), .mem_awlen_o(awlen), .mem_awsize_o(awsize),
    .mem_awburst_o(awburst), .mem_awlock_o(awlock), .mem_awcache_o(awcache),
    .mem_awprot_o(awprot), .mem_awqos_o(awqos), .mem_awregion_o(awregion),
    .mem_awuser_o(awuser), .mem_awvalid_o(awvalid), .mem_awready_i(awready),
    .mem_wdata_c(wdata), .mem_wstrb_c(wstrb), .mem_wlast_c(wlast), .mem_wuser_o(wuser),
    .mem_wvalid_c(wvalid), .mem_wready_i(wready),
    .mem_bid_i(1'b0), .mem_bresp_i(bresp), .mem_bvalid_i(bvalid), .mem_bready_c(bready),
    .mem_arid_o(arid), .mem_araddr_o(araddr), .mem_arlen_o(arlen), .mem_arsize_o(arsize),
    .mem_arburst_o(arburst), .mem_arlock_o(arlock), .mem_arcache_o(arcache),
    .mem_arprot_o(arprot), .mem_arqos_o(arqos), .mem_arregion_o(arregion),
    .mem_aruser_o(aruser), .mem_arvalid_o(arvalid),
    .mem_rid_i(1'b0), .mem_rdata_i('0), .mem_rresp_i(2'b00), .mem_rlast_i(1'b0),
    .mem_rvalid_i(1'b0), .mem_rready_o(rready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr;
    int          size;
    int          bursts;
    int          len0;
    bit          exp_err;
    bit          stall;
    bit          tlast_bad;
    int          slverr_burst;
    bit          poke;
  } vec_t;

  typedef struct { logic [31:0] addr; logic [7:0] len; } aw_exp_t;
  typedef struct { logic [63:0] data; logic [7:0] strb; logic last; } w_exp_t;
  typedef struct { logic [63:0] data; logic last; } src_t;

  aw_exp_t aw_q[$];
  w_exp_t  w_q[$];
  src_t    src_q[$];
  vec_t    vecs[11];

  int chk_cnt = 0, err_cnt = 0;
  int aw_cnt, b_cnt, w_cnt, done_cnt = 0, first_len;
  int b_pend, bi, slverr_burst;
  bit stall_en;
  bit aw_hs_f, w_hs_f, wlast_hs_f, b_hs_f, t_hs_f;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    chk_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL %s got=0x%0h exp=0x%0h @%0t", name, got, exp, $time);
    end
  endtask

  // Observer: handshakes are stable between the negedge and the next posedge.
  always @(negedge clk) begin
    aw_hs_f    = !rst && awvalid && awready;
    w_hs_f     = !rst && wvalid && wready;
    wlast_hs_f = w_hs_f && wlast;
    b_hs_f     = !rst && bvalid && bready;
    t_hs_f     = !rst && tvalid && tready;
    if (t_hs_f != w_hs_f) check("stream_w_pair", 64'(t_hs_f), 64'(w_hs_f));
    if (aw_hs_f) begin
      aw_exp_t e;
      check("aw_outstanding", 64'(aw_cnt - b_cnt), 64'(0));
      check("aw_pending", 64'(aw_q.size() != 0), 64'(1));
      if (aw_cnt == 0) first_len = int'(awlen);
      aw_cnt++;
      if (aw_q.size() != 0) begin
        e = aw_q.pop_front();
        check("awaddr", 64'(awaddr), 64'(e.addr));
        check("awlen", 64'(awlen), 64'(e.len));
        check("aw_fields", 64'({awsize, awburst, awid, awlock, awcache}), 64'({3'd3, 2'd1, 1'b0, 1'b0, 4'd0}));
      end
    end
    if (w_hs_f) begin
      w_exp_t e;
      w_cnt++;
      check("w_pending", 64'(w_q.size() != 0), 64'(1));
      if (w_q.size() != 0) begin
        e = w_q.pop_front();
        check("wdata", wdata, e.data);
        check("wstrb", 64'(wstrb), 64'(e.strb));
        check("wlast", 64'(wlast), 64'(e.last));
      end
    end
    if (b_hs_f) b_cnt++;
    if (done) done_cnt++;
  end

  // AXI write slave with optional ready stalls and a selectable SLVERR burst.
  always @(posedge clk) begin
    #1;
    if (rst) begin
      awready = 1'b0; wready = 1'b0; bvalid = 1'b0; bresp = 2'b00; b_pend = 0;
    end else begin
      if (b_hs_f) bvalid = 1'b0;
      if (wlast_hs_f) b_pend++;
      if (!bvalid && b_pend > 0) begin
        b_pend--;
        bi++;
        bvalid = 1'b1;
        bresp  = (bi == slverr_burst) ? 2'b10 : 2'b00;
      end
      awready = stall_en ? ($urandom_range(0, 3) != 0) : 1'b1;
      wready  = stall_en ? ($urandom_range(0, 3) != 0) : 1'b1;
    end
  end

  // Stream source: holds a beat until accepted.
  always @(posedge clk) begin
    #1;
    if (rst) begin
      tvalid = 1'b0;
    end else begin
      if (t_hs_f) begin
        void'(src_q.pop_front());
        tvalid = 1'b0;
      end
      if (!tvalid && src_q.size() > 0) tvalid = stall_en ? ($urandom_range(0, 3) != 0) : 1'b1;
      if (src_q.size() > 0) begin
        tdata = src_q[0].data;
        tlast = src_q[0].last;
      end
    end
  end

  // Reference burst split and beat list for one packet.
  task automatic prep(input vec_t v, input int tag);
    logic [31:0] cur;
    int words, total, g, len, bnd, rem;
    logic [7:0] ls;
    w_exp_t we;
    src_t s;
    cur   = {v.addr[31:3], 3'b000};
    words = (v.size + 7) / 8;
    total = words;
    rem   = v.size % 8;
    ls    = (rem == 0) ? 8'hFF : 8'((1 << rem) - 1);
    g     = 0;
    while (words > 0) begin
      bnd = (4096 - int'(cur[11:0])) / 8;
      len = words;
      if (bnd < len) len = bnd;
      if (len > 256) len = 256;
      aw_q.push_back('{cur, 8'(len - 1)});
      for (int k = 0; k < len; k++) begin
        we.data = {32'(tag), 32'(g)};
        we.strb = (g == total - 1) ? ls : 8'hFF;
        we.last = (k == len - 1);
        w_q.push_back(we);
        s.data = we.data;
        s.last = v.tlast_bad ? (g == 0) : (g == total - 1);
        src_q.push_back(s);
        g++;
      end
      cur   = cur + 32'(len * 8);
      words = words - len;
    end
    stall_en     = v.stall;
    slverr_burst = v.slverr_burst;
    aw_cnt = 0; b_cnt = 0; w_cnt = 0; bi = 0; first_len = -1;
  endtask

  task automatic pulse_start(input logic [31:0] a, input int sz);
    @(posedge clk); #1;
    addr = a; pkt_size = PW'(sz); wr_stb = 1'b1;
    @(posedge clk); #1;
    wr_stb = 1'b0;
  endtask

  task automatic run_vec(input vec_t v, input int tag);
    int d0, c;
    prep(v, tag);
    d0 = done_cnt;
    pulse_start(v.addr, v.size);
    @(negedge clk);
    check("start_busy", 64'(busy), 64'(v.size != 0));
    check("start_err_clr", 64'(err), 64'(0));
    if (v.size == 0) check("zero_done_next", 64'(done), 64'(1));
    if (v.poke) pulse_start(32'h5000, 8);
    c = 0;
    while (!done && c < 20000) begin
      @(negedge clk);
      c++;
    end
    check("done_in_time", 64'(done), 64'(1));
    check("done_busy_low", 64'(busy), 64'(0));
    check("b_count", 64'(b_cnt), 64'(v.bursts));
    check("aw_count", 64'(aw_cnt), 64'(v.bursts));
    if (v.bursts > 0) check("first_awlen", 64'(first_len), 64'(v.len0));
    check("err_at_done", 64'(err), 64'(v.exp_err));
    @(negedge clk);
    check("done_one_cycle", 64'(done), 64'(0));
    repeat (4) @(negedge clk);
    check("done_pulses", 64'(done_cnt - d0), 64'(1));
    check("queues_drained", 64'(aw_q.size() + w_q.size() + src_q.size()), 64'(0));
    check("err_sticky", 64'(err), 64'(v.exp_err));
  endtask

  initial begin
    int c;
    vecs[0]  = '{32'h0000_1000,   64, 1,   7, 1'b0, 1'b0, 1'b0, 0, 1'b0};
    vecs[1]  = '{32'h0000_0000, 2048, 1, 255, 1'b0, 1'b0, 1'b0, 0, 1'b0};
    vecs[2]  = '{32'h0000_0000, 4096, 2, 255, 1'b0, 1'b0, 1'b0, 0, 1'b0};
    vecs[3]  = '{32'h0000_0FF0,   64, 2,   1, 1'b0, 1'b0, 1'b0, 0, 1'b0};
    vecs[4]  = '{32'h0000_0000,   13, 1,   1, 1'b0, 1'b0, 1'b0, 0, 1'b0};
    vecs[5]  = '{32'h0000_2F00,  600, 2,  31, 1'b1, 1'b1, 1'b0, 2, 1'b0};
    vecs[6]  = '{32'h0000_1003,   20, 1,   2, 1'b0, 1'b1, 1'b0, 0, 1'b0};
    vecs[7]  = '{32'h0000_07F8, 5000, 4, 255, 1'b0, 1'b1, 1'b0, 0, 1'b0};
    vecs[8]  = '{32'h0000_0100,   24, 1,   2, 1'b1, 1'b0, 1'b1, 0, 1'b0};
    vecs[9]  = '{32'h0000_3000,    0, 0,   0, 1'b0, 1'b0, 1'b0, 0, 1'b0};
    vecs[10] = '{32'h0000_1000,   64, 1,   7, 1'b0, 1'b1, 1'b0, 0, 1'b1};

    rst = 1'b1; wr_stb = 1'b0; addr = '0; pkt_size = '0;
    tdata = '0; tlast = 1'b0; tvalid = 1'b0;
    awready = 1'b0; wready = 1'b0; bvalid = 1'b0; bresp = 2'b00;
    stall_en = 1'b0; slverr_burst = 0; bi = 0; b_pend = 0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_status", 64'({busy, done, err}), 64'(0));
    check("rst_valids", 64'({awvalid, wvalid, tready, bready, arvalid}), 64'(0));
    check("rst_aw_regs", 64'({awaddr, awlen}), 64'(0));
    check("rst_rready", 64'(rready), 64'(1));
    rst = 1'b0;

    for (int i = 0; i < 11; i++) run_vec(vecs[i], i + 1);

    // Reset while data is streaming, then a clean small transfer.
    prep('{32'h0, 800, 1, 99, 1'b0, 1'b1, 1'b0, 0, 1'b0}, 100);
    pulse_start(32'h0, 800);
    c = 0;
    while (w_cnt < 3 && c < 2000) begin
      @(negedge clk);
      c++;
    end
    check("rst_mid_reached_data", 64'(w_cnt >= 3), 64'(1));
    #2 rst = 1'b1;
    #1;
    check("rst_mid_valids", 64'({awvalid, wvalid, tready, bready}), 64'(0));
    check("rst_mid_status", 64'({busy, done, err}), 64'(0));
    repeat (2) @(posedge clk);
    aw_q.delete(); w_q.delete(); src_q.delete();
    @(negedge clk);
    check("rst_mid_aw_regs", 64'({awaddr, awlen}), 64'(0));
    rst = 1'b0;
    run_vec('{32'h0000_0040, 8, 1, 0, 1'b0, 1'b0, 1'b0, 0, 1'b0}, 101);

    $display("CHECKS %0d ERRORS %0d", chk_cnt, err_cnt);
    $finish;
  end

endmodule

// File: doc/axi4_stream_to_axi4.md
AXI4_STREAM_TO_AXI4 -- requirements
Module: axi4_stream_to_axi4

Interface
REQ-001 Parameters (name, default, meaning), one per line:
- DATA_WIDTH, 64, data bus width in bits, both interfaces.
- ADDR_WIDTH, 32, AXI4 address width.
- ID_WIDTH / AWUSER_WIDTH / WUSER_WIDTH / ARUSER_WIDTH / TUSER_WIDTH / TDEST_WIDTH, 1, sideband widths.
- MAX_PKT_SIZE_B, 2048, largest packet in bytes.
- MAX_PKT_SIZE_WIDTH, $clog2(MAX_PKT_SIZE_B*4), width of pkt_size_i.
REQ-002 Ports (name, direction, width, meaning), one per line:
- clk_i, in, 1, single clock.
- rst_i, in, 1, asynchronous, active-high reset.
- pkt_size_i, in, MAX_PKT_SIZE_WIDTH, packet length in bytes, sampled on start.
- addr_i, in, ADDR_WIDTH, destination byte address, sampled on start.
- wr_stb_i, in, 1, start request, honoured only in IDLE_S.
- busy_o, out, 1, high whenever state != IDLE_S.
- done_o, out, 1, one-cycle pulse after the last B response of a packet.
- err_o, out, 1, sticky error flag, cleared on next accepted start.
- pkt_i, axi4_stream_if.slave, DATA_WIDTH, packet source.
- mem_o, axi4_if.master, DATA_WIDTH, write-only memory port.

Function
REQ-003 Start: in IDLE_S with wr_stb_i=1, the block latches cur_addr={addr_i[ADDR_WIDTH-1:W],W'(0)}, W=$clog2(DATA_WIDTH/8), and words_left=ceil(pkt_size_i/(DATA_WIDTH/8)); it then goes to CALC_BURST_S.
REQ-004 pkt_size_i=0 at start: done_o pulses next cycle, no AXI traffic, state returns to IDLE_S.
REQ-005 States: IDLE_S, CALC_BURST_S, ADDR_S, DATA_S, RESP_S.
- CALC_BURST_S->ADDR_S after 1 cycle.
- ADDR_S->DATA_S on AW handshake.
- DATA_S->RESP_S on the W handshake with wlast=1.
- RESP_S->CALC_BURST_S on B handshake if words_left>0, else ->IDLE_S with done_o=1 in that cycle.
REQ-006 Burst length = min(words_left, 256, words to next 4 KB boundary from cur_addr); a burst never crosses a 4 KB boundary.
REQ-007 awlen = burst length-1 and awaddr=cur_addr, both registered in CALC_BURST_S; awvalid set in CALC_BURST_S, held until awready.
REQ-008 Constant AW fields: awsize=$clog2(DATA_WIDTH/8), awburst=INCR (2'b01), awid/awlock/awcache/awprot/awqos/awregion/awuser=0.
REQ-009 Read channel tied off: arvalid=0, rready=1, other AR fields 0.
REQ-010 bready=1 only in RESP_S.
REQ-011 In DATA_S: wvalid=pkt_i.tvalid, pkt_i.tready=mem_o.wready, wdata=pkt_i.tdata. Outside DATA_S: pkt_i.tready=0 and wvalid=0. No stream beat is accepted without a matching W handshake.
REQ-012 wstrb=all-ones on every beat except the packet's final beat, which carries last_strb: all-ones if pkt_size_i mod bytes-per-word = 0, else the low (pkt_size_i mod bytes-per-word) bits set.
REQ-013 wlast=1 on the final beat of each burst, from an internal beat counter; the stream tlast does not drive wlast.
REQ-014 Each W handshake decrements words_left and the burst counter and adds DATA_WIDTH/8 to cur_addr.
REQ-015 tlast mismatch: tlast=1 on a non-final packet beat, or tlast=0 on the final beat, sets err_o. The transfer still completes for the full latched length.
REQ-016 bresp != OKAY sets err_o. Remaining bursts are still issued.
REQ-017 wr_stb_i while busy_o=1 is ignored, with no effect on latched values.
REQ-018 AW and W are strictly serialised per burst; at most one burst is outstanding.

Reset
REQ-019 On rst_i=1, asynchronously: state=IDLE_S; awvalid=0, wvalid=0, bready=0, pkt_i.tready=0; busy_o=0, done_o=0, err_o=0; awaddr=0, awlen=0; counters and addresses=0.
REQ-020 Reset mid-burst abandons the transfer with no further AXI activity; the next start after reset behaves as from power-up.

Verification
REQ-021 The bench covers these directed scenarios:
- DATA_WIDTH=64, addr=0x1000, size=64, ready always high -> one burst awlen=7, 8 beats, wlast on beat 8, wstrb=0xFF, one done_o pulse.
- size=2048, addr=0x0 -> single burst awlen=255, done_o after B.
- size=4096, addr=0x0 -> bursts at 0x0 and 0x800, each awlen=255.
- addr=0x0FF0, size=64 -> bursts awaddr=0x0FF0 awlen=1, then awaddr=0x1000 awlen=5.
- size=13 -> 2 beats, wstrb 0xFF then 0x1F, tlast on beat 2, err_o=0.
- Random wready/tvalid/awready stalls, bresp=SLVERR on the 2nd burst -> data order preserved, err_o=1 until next start.
- rst_i asserted during DATA_S -> all valids low immediately, busy_o=0; next size=8 transfer completes normally.
